// File: rtl/mc_controller_if.sv
// mc_controller_if: control/status bundle between the multicycle controller and the datapath
interface mc_controller_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH = 32
);
  logic mc_i_ce;
  logic [OPCODE_WIDTH-1:0] mc_i_opcode;
  logic mc_i_mem_ready;
  logic mc_o_PCWrite, mc_o_PCWriteCond, mc_o_IorD, mc_o_MemRead, mc_o_MemWrite;
  logic mc_o_IRWrite, mc_o_MemtoReg, mc_o_RegDst, mc_o_RegWrite, mc_o_ALUSrcA;
  logic [1:0] mc_o_ALUSrcB, mc_o_ALUOp, mc_o_PCSource;
  logic [3:0] mc_o_state;
  logic mc_o_illegal;
  logic [CNT_WIDTH-1:0] mc_o_retired;
  modport master (
    input mc_i_ce, mc_i_opcode, mc_i_mem_ready,
    output mc_o_PCWrite, mc_o_PCWriteCond, mc_o_IorD, mc_o_MemRead, mc_o_MemWrite,
    output mc_o_IRWrite, mc_o_MemtoReg, mc_o_RegDst, mc_o_RegWrite, mc_o_ALUSrcA,
    output mc_o_ALUSrcB, mc_o_ALUOp, mc_o_PCSource, mc_o_state, mc_o_illegal, mc_o_retired
  );
  modport slave (
    output mc_i_ce, mc_i_opcode, mc_i_mem_ready,
    input mc_o_PCWrite, mc_o_PCWriteCond, mc_o_IorD, mc_o_MemRead, mc_o_MemWrite,
    input mc_o_IRWrite, mc_o_MemtoReg, mc_o_RegDst, mc_o_RegWrite, mc_o_ALUSrcA,
    input mc_o_ALUSrcB, mc_o_ALUOp, mc_o_PCSource, mc_o_state, mc_o_illegal, mc_o_retired
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with memory-latency handling, stall and retire counter
module mc_controller #(
  parameter int OPCODE_WIDTH = 6,
  parameter int MEM_LATENCY = 1,
  parameter int USE_READY = 0,
  parameter int CNT_WIDTH = 32
) (
  input logic mc_clk,
  input logic mc_rst,
  mc_controller_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7,
                         BEQ = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW = OPCODE_WIDTH'(6'b100011), OP_SW = OPCODE_WIDTH'(6'b101011),
                                      OP_R = OPCODE_WIDTH'(6'b000000), OP_BEQ = OPCODE_WIDTH'(6'b000100),
                                      OP_ADDI = OPCODE_WIDTH'(6'b001000), OP_J = OPCODE_WIDTH'(6'b000010);
  logic [3:0] state_q, state_d, nxt, wait_q, wait_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic illegal_q, illegal_d;
  logic ce, mem_st, done, last;
  logic [OPCODE_WIDTH-1:0] op;
  always_comb begin
    ce = bus.mc_i_ce;
    op = bus.mc_i_opcode;
    mem_st = state_q inside {FETCH, MEMRD, MEMWR};
    done = mem_st && (USE_READY != 0 ? bus.mc_i_mem_ready : wait_q == 4'(MEM_LATENCY - 1));
    last = state_q inside {MEMWB, RWB, BEQ, ADDIWB, JUMP} || (state_q == MEMWR && done);
    nxt = FETCH;
    case (state_q)
      FETCH:   nxt = done ? DECODE : FETCH;
      DECODE:  nxt = (op == OP_LW || op == OP_SW) ? MEMADR : op == OP_R ? EXEC : op == OP_BEQ ? BEQ :
                     op == OP_ADDI ? ADDIEX : op == OP_J ? JUMP : FETCH;
      MEMADR:  nxt = op == OP_LW ? MEMRD : MEMWR;
      MEMRD:   nxt = done ? MEMWB : MEMRD;
      MEMWR:   nxt = done ? FETCH : MEMWR;
      EXEC:    nxt = RWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
    state_d = ce ? nxt : state_q;
    // the latency counter only runs while a memory state is still waiting
    wait_d = ce ? ((mem_st && !done && USE_READY == 0) ? wait_q + 4'd1 : 4'd0) : wait_q;
    retired_d = (ce && last) ? retired_q + CNT_WIDTH'(1) : retired_q;
    illegal_d = ce ? (state_q == DECODE && nxt == FETCH) : illegal_q;
  end
  always_comb begin
    bus.mc_o_MemRead = state_q inside {FETCH, MEMRD};
    bus.mc_o_IorD = state_q inside {MEMRD, MEMWR};
    bus.mc_o_IRWrite = ce && state_q == FETCH && done;
    bus.mc_o_PCWrite = ce && ((state_q == FETCH && done) || state_q == JUMP);
    bus.mc_o_PCWriteCond = ce && state_q == BEQ;
    bus.mc_o_MemWrite = ce && state_q == MEMWR;
    bus.mc_o_RegWrite = ce && (state_q inside {MEMWB, RWB, ADDIWB});
    bus.mc_o_MemtoReg = state_q == MEMWB;
    bus.mc_o_RegDst = state_q == RWB;
    bus.mc_o_ALUSrcA = state_q inside {MEMADR, EXEC, BEQ, ADDIEX};
    bus.mc_o_ALUSrcB = state_q == FETCH ? 2'b01 : state_q == DECODE ? 2'b11 :
                       (state_q inside {MEMADR, ADDIEX}) ? 2'b10 : 2'b00;
    bus.mc_o_ALUOp = state_q == EXEC ? 2'b10 : state_q == BEQ ? 2'b01 : 2'b00;
    bus.mc_o_PCSource = state_q == BEQ ? 2'b01 : state_q == JUMP ? 2'b10 : 2'b00;
    bus.mc_o_state = state_q;
    bus.mc_o_illegal = illegal_q;
    bus.mc_o_retired = retired_q;
  end
  always_ff @(posedge mc_clk)
    if (mc_rst) begin
      state_q <= FETCH;
      wait_q <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench over three controller configurations
module tb_mc_controller;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  mc_controller_if #(.CNT_WIDTH(4)) i0();
  mc_controller_if i1();
  mc_controller_if i2();
  mc_controller #(.CNT_WIDTH(4)) d0 (.mc_clk(clk), .mc_rst(rst), .bus(i0));
  mc_controller #(.MEM_LATENCY(3)) d1 (.mc_clk(clk), .mc_rst(rst), .bus(i1));
  mc_controller #(.USE_READY(1)) d2 (.mc_clk(clk), .mc_rst(rst), .bus(i2));
  // ctl = {IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite, MemRead, illegal, ALUOp}
  localparam logic [8:0] K0 = 9'b000000000, KFD = 9'b110001000, KFW = 9'b000001000,
                         KRW = 9'b000100000, KMW = 9'b000010000, KEX = 9'b000000010,
                         KBQ = 9'b001000001, KJ = 9'b010000000, KIL = 9'b000000100;
  typedef struct {
    int d;
    logic [5:0] op;
    int st;
    logic [8:0] ctl;
    int ret;
    logic ce, rdy, r;
  } row_t;
  row_t sb[$];
  int checks = 0, errors = 0, sel = 0;
  logic [3:0] o_st;
  logic [8:0] o_ctl, c0, c1, c2;
  logic [31:0] o_ret;
  always_comb begin
    c0 = {i0.mc_o_IRWrite, i0.mc_o_PCWrite, i0.mc_o_PCWriteCond, i0.mc_o_RegWrite, i0.mc_o_MemWrite,
          i0.mc_o_MemRead, i0.mc_o_illegal, i0.mc_o_ALUOp};
    c1 = {i1.mc_o_IRWrite, i1.mc_o_PCWrite, i1.mc_o_PCWriteCond, i1.mc_o_RegWrite, i1.mc_o_MemWrite,
          i1.mc_o_MemRead, i1.mc_o_illegal, i1.mc_o_ALUOp};
    c2 = {i2.mc_o_IRWrite, i2.mc_o_PCWrite, i2.mc_o_PCWriteCond, i2.mc_o_RegWrite, i2.mc_o_MemWrite,
          i2.mc_o_MemRead, i2.mc_o_illegal, i2.mc_o_ALUOp};
    o_st = sel == 0 ? i0.mc_o_state : sel == 1 ? i1.mc_o_state : i2.mc_o_state;
    o_ctl = sel == 0 ? c0 : sel == 1 ? c1 : c2;
    o_ret = sel == 0 ? 32'(i0.mc_o_retired) : sel == 1 ? i1.mc_o_retired : i2.mc_o_retired;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic p(input int d, input logic [5:0] op, input int st, input logic [8:0] ctl, input int ret,
                   input logic ce = 1'b1, input logic rdy = 1'b0, input logic r = 1'b0);
    row_t x;
    x.d = d; x.op = op; x.st = st; x.ctl = ctl; x.ret = ret; x.ce = ce; x.rdy = rdy; x.r = r;
    sb.push_back(x);
  endtask
  initial begin
    row_t x;
    int n = 0;
    {i0.mc_i_ce, i1.mc_i_ce, i2.mc_i_ce} = 3'b000;
    {i0.mc_i_mem_ready, i1.mc_i_mem_ready, i2.mc_i_mem_ready} = 3'b000;
    {i0.mc_i_opcode, i1.mc_i_opcode, i2.mc_i_opcode} = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p(0, 6'h00, 0, KFD, 0);
    p(0, 6'h00, 1, K0, 0);
    p(0, 6'h00, 6, KEX, 0);
    p(0, 6'h00, 7, KRW, 0);
    p(0, 6'h00, 0, KFD, 1);
    p(0, 6'h3f, 1, K0, 1);
    p(0, 6'h00, 0, KFD | KIL, 1);
    p(0, 6'h08, 1, K0, 1);
    p(0, 6'h08, 9, K0, 1);
    for (int k = 0; k < 4; k++) p(0, 6'h08, 10, K0, 1, 1'b0);
    p(0, 6'h08, 10, KRW, 1);
    p(0, 6'h00, 0, KFD, 2);
    for (int k = 0; k < 5; k++) begin
      p(0, 6'h02, 1, K0, 2 + k);
      p(0, 6'h02, 11, KJ, 2 + k);
      p(0, 6'h00, 0, KFD, 3 + k);
    end
    p(0, 6'h23, 1, K0, 7);
    p(0, 6'h23, 2, K0, 7);
    p(0, 6'h23, 3, KFW, 7, 1'b1, 1'b0, 1'b1);
    p(0, 6'h00, 0, KFD, 0);
    for (int k = 0; k < 16; k++) begin
      p(0, 6'h02, 1, K0, k);
      p(0, 6'h02, 11, KJ, k);
      p(0, 6'h00, 0, KFD, (k + 1) % 16);
    end
    p(1, 6'h23, 0, KFW, 0);
    p(1, 6'h23, 0, KFW, 0);
    p(1, 6'h23, 0, KFD, 0);
    p(1, 6'h23, 1, K0, 0);
    p(1, 6'h23, 2, K0, 0);
    for (int k = 0; k < 3; k++) p(1, 6'h23, 3, KFW, 0);
    p(1, 6'h23, 4, KRW, 0);
    p(1, 6'h23, 0, KFW, 1);
    p(2, 6'h00, 0, KFW, 0, 1'b0, 1'b1);
    p(2, 6'h00, 0, KFW, 0, 1'b1, 1'b0);
    p(2, 6'h00, 0, KFD, 0, 1'b1, 1'b1);
    p(2, 6'h2b, 1, K0, 0);
    p(2, 6'h2b, 2, K0, 0);
    for (int k = 0; k < 5; k++) p(2, 6'h2b, 5, KMW, 0, 1'b1, 1'b0);
    p(2, 6'h2b, 5, KMW, 0, 1'b1, 1'b1);
    p(2, 6'h00, 0, KFW, 1, 1'b1, 1'b0);
    p(2, 6'h00, 0, KFD, 1, 1'b1, 1'b1);
    p(2, 6'h04, 1, K0, 1);
    p(2, 6'h04, 8, KBQ, 1);
    p(2, 6'h00, 0, KFW, 2);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      sel = x.d;
      rst = x.r;
      i0.mc_i_ce = x.d == 0 && x.ce;
      i1.mc_i_ce = x.d == 1 && x.ce;
      i2.mc_i_ce = x.d == 2 && x.ce;
      {i0.mc_i_mem_ready, i1.mc_i_mem_ready, i2.mc_i_mem_ready} = {3{x.rdy}};
      {i0.mc_i_opcode, i1.mc_i_opcode, i2.mc_i_opcode} = {3{x.op}};
      #1;
      check($sformatf("state[%0d]", n), 32'(o_st), x.st);
      check($sformatf("ctl[%0d]", n), 32'(o_ctl), 32'(x.ctl));
      check($sformatf("retired[%0d]", n), o_ret, x.ret);
      n++;
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
